// File: rtl/v810_exc_seq.sv
// V810 exception/interrupt entry sequencer: saves PC/PSW/ECR, builds the handler PSW, jumps to the handler.
// Optional macro V810_FATAL_HALT_EN: an entry taken while PSW.NP is already set traps into a halting FATAL state.
module v810_exc_seq (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        IF,
    output logic        ACK,
    input  logic        NP,
    input  logic [3:0]  IEL,
    input  logic [15:0] CC,
    input  logic [31:0] HA,
    input  logic        BOUND,
    input  logic [31:0] PC_IN,
    input  logic [31:0] PSW_IN,
    input  logic [31:0] ECR_IN,
    output logic        SR_WE,
    output logic [2:0]  SR_SEL,
    output logic [31:0] SR_WD,
    output logic        PSW_WE,
    output logic [31:0] PSW_WD,
    output logic        PC_LD,
    output logic [31:0] PC_NEW,
    output logic        BUSY,
    output logic        HALT,
    output logic [2:0]  STATE_DBG
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SPC    = 3'd2,
        S_SPSW   = 3'd3,
        S_SECR   = 3'd4,
        S_SETPSW = 3'd5,
        S_JUMP   = 3'd6,
        S_FATAL  = 3'd7
    } state_t;

    localparam logic [15:0] RESET_CC = 16'hFFF0;
    localparam logic [2:0]  SEL_EIPC = 3'd0;
    localparam logic [2:0]  SEL_EIPSW = 3'd1;
    localparam logic [2:0]  SEL_FEPC = 3'd2;
    localparam logic [2:0]  SEL_FEPSW = 3'd3;
    localparam logic [2:0]  SEL_ECR = 3'd4;

    state_t      state_q, state_d;
    logic [31:0] pc_q, psw_q, ha_q;
    logic [15:0] cc_q;
    logic        np_q;
    logic [3:0]  iel_q;
    logic        is_rst;
    logic [31:0] psw_new;

    // Mux outputs are captured alongside PC/PSW so the entry cannot be disturbed once started.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            psw_q   <= '0;
            ha_q    <= '0;
            cc_q    <= '0;
            np_q    <= 1'b0;
            iel_q   <= '0;
        end else if (CE) begin
            state_q <= state_d;
            if (state_q == S_WAIT) begin
                pc_q  <= PC_IN;
                psw_q <= PSW_IN;
                ha_q  <= HA;
                cc_q  <= CC;
                np_q  <= NP;
                iel_q <= IEL;
            end
        end
    end

    assign is_rst    = (cc_q == RESET_CC);
    assign STATE_DBG = state_q;
    assign ACK       = RESn && (state_q == S_IDLE) && IF && BOUND && CE;

    always_comb begin
        psw_new     = psw_q;
        psw_new[12] = 1'b1;
        psw_new[13] = 1'b0;
        if (np_q) psw_new[15] = 1'b1;
        else      psw_new[14] = 1'b1;
        if (iel_q != 4'd0) psw_new[19:16] = iel_q;
    end

    always_comb begin
        state_d = state_q;
        SR_WE   = 1'b0;
        SR_SEL  = 3'd0;
        SR_WD   = '0;
        PSW_WE  = 1'b0;
        PSW_WD  = '0;
        PC_LD   = 1'b0;
        PC_NEW  = '0;
        BUSY    = 1'b1;
        HALT    = 1'b0;
        case (state_q)
            S_IDLE: begin
                BUSY = 1'b0;
                if (IF && BOUND) state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef V810_FATAL_HALT_EN
                // The PSW being captured this cycle is the one that decides the trap.
                if (PSW_IN[15] && (CC != RESET_CC)) state_d = S_FATAL;
                else                                state_d = S_SPC;
`else
                state_d = S_SPC;
`endif
            end
            S_SPC: begin
                state_d = S_SPSW;
                if (!is_rst) begin
                    SR_WE  = 1'b1;
                    SR_SEL = np_q ? SEL_FEPC : SEL_EIPC;
                    SR_WD  = pc_q;
                end
            end
            S_SPSW: begin
                state_d = S_SECR;
                if (!is_rst) begin
                    SR_WE  = 1'b1;
                    SR_SEL = np_q ? SEL_FEPSW : SEL_EIPSW;
                    SR_WD  = psw_q;
                end
            end
            S_SECR: begin
                state_d = S_SETPSW;
                SR_WE   = 1'b1;
                SR_SEL  = SEL_ECR;
                if (is_rst)    SR_WD = 32'h0000FFF0;
                else if (np_q) SR_WD = {cc_q, ECR_IN[15:0]};
                else           SR_WD = {ECR_IN[31:16], cc_q};
            end
            S_SETPSW: begin
                state_d = S_JUMP;
                PSW_WE  = 1'b1;
                PSW_WD  = is_rst ? 32'h00008000 : psw_new;
            end
            S_JUMP: begin
                state_d = S_IDLE;
                PC_LD   = 1'b1;
                PC_NEW  = is_rst ? 32'hFFFFFFF0 : ha_q;
            end
            S_FATAL: begin
`ifdef V810_FATAL_HALT_EN
                HALT = 1'b1;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_v810_exc_seq.sv
// Bench for v810_exc_seq: vector table of entries, strobe scoreboard, plus reset/stall/fatal corner sequences.
module tb_v810_exc_seq;

    logic        CLK, RESn, CE, IF, ACK, NP, BOUND;
    logic [3:0]  IEL;
    logic [15:0] CC;
    logic [31:0] HA, PC_IN, PSW_IN, ECR_IN;
    logic        SR_WE, PSW_WE, PC_LD, BUSY, HALT;
    logic [2:0]  SR_SEL, STATE_DBG;
    logic [31:0] SR_WD, PSW_WD, PC_NEW;

    v810_exc_seq dut (
        .CLK(CLK), .RESn(RESn), .CE(CE), .IF(IF), .ACK(ACK), .NP(NP), .IEL(IEL),
        .CC(CC), .HA(HA), .BOUND(BOUND), .PC_IN(PC_IN), .PSW_IN(PSW_IN), .ECR_IN(ECR_IN),
        .SR_WE(SR_WE), .SR_SEL(SR_SEL), .SR_WD(SR_WD), .PSW_WE(PSW_WE), .PSW_WD(PSW_WD),
        .PC_LD(PC_LD), .PC_NEW(PC_NEW), .BUSY(BUSY), .HALT(HALT), .STATE_DBG(STATE_DBG)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [15:0] cc;
        logic        np;
        logic [3:0]  iel;
        logic [31:0] ha;
        logic [31:0] pc;
        logic [31:0] psw;
        logic [31:0] ecr;
        logic        save;
        logic [31:0] e_ecr;
        logic [31:0] e_psw;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[5];
    logic [39:0] exp_q[$];
    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ev(input string name, input logic [39:0] ev);
        logic [39:0] e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected strobe %h at %0t", name, ev, $time);
        end else begin
            e = exp_q.pop_front();
            if (e !== ev) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h at %0t", name, ev, e, $time);
            end
        end
    endtask

    // scoreboard: an event is {kind, sel, data}; kind 1 = SR write, 2 = PSW write, 3 = PC load
    always @(negedge CLK) begin
        if (RESn && CE) begin
            if (SR_WE)  check_ev("sr_write", {4'd1, 1'b0, SR_SEL, SR_WD});
            if (PSW_WE) check_ev("psw_write", {4'd2, 4'd0, PSW_WD});
            if (PC_LD)  check_ev("pc_load", {4'd3, 4'd0, PC_NEW});
        end
    end

    task automatic drive_vec(input vec_t v);
        CC = v.cc; NP = v.np; IEL = v.iel; HA = v.ha;
        PC_IN = v.pc; PSW_IN = v.psw; ECR_IN = v.ecr;
    endtask

    task automatic push_exp(input vec_t v);
        if (v.save) begin
            exp_q.push_back({4'd1, 1'b0, (v.np ? 3'd2 : 3'd0), v.pc});
            exp_q.push_back({4'd1, 1'b0, (v.np ? 3'd3 : 3'd1), v.psw});
        end
        exp_q.push_back({4'd1, 1'b0, 3'd4, v.e_ecr});
        exp_q.push_back({4'd2, 4'd0, v.e_psw});
        exp_q.push_back({4'd3, 4'd0, v.e_pc});
    endtask

    // driver: starts just after a falling edge, ends on a falling edge back in IDLE
    task automatic run_entry(input vec_t v, input int bound_delay, input int stall);
        int waited;
        int n;
        logic got;
        logic seen;
        drive_vec(v);
        IF = 1'b1;
        BOUND = 1'b0;
        for (int i = 0; i < bound_delay; i++) begin
            #1;
            chk("no_ack_bound0", {ACK, BUSY}, 2'b00);
            @(negedge CLK);
        end
        BOUND = 1'b1;
        got = 1'b0;
        waited = 0;
        while (!got && waited < 20) begin
            #1;
            if (ACK) got = 1'b1;
            else begin
                waited++;
                @(negedge CLK);
            end
        end
        chk("ack_first_cycle", {got, waited[7:0]}, {1'b1, 8'd0});
        if (!got) return;
        push_exp(v);
        @(posedge CLK);
        #1;
        IF = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge CLK);
            n++;
            if (PC_LD) seen = 1'b1;
            if (n == 4 && stall > 0) begin
                #2;
                CE = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    @(negedge CLK);
                    #1;
                    chk("ce_hold", {SR_WE, SR_SEL, STATE_DBG, BUSY}, {1'b1, 3'd4, 3'd4, 1'b1});
                end
                CE = 1'b1;
            end
        end
        chk("pc_ld_cycle", n, 6);
        @(negedge CLK);
        chk("back_idle", {BUSY, ACK, STATE_DBG}, {1'b0, 1'b0, 3'd0});
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        vec_t vf;
        logic bad;
        // {cc, np, iel, ha, pc, psw, ecr, save, e_ecr, e_psw, e_pc}
        vecs[0] = {16'hFFF0, 1'b0, 4'd0, 32'h00000000, 32'h00001111, 32'h00000000, 32'hABCD1234,
                   1'b0, 32'h0000FFF0, 32'h00008000, 32'hFFFFFFF0};
        vecs[1] = {16'hFE50, 1'b0, 4'd6, 32'hFFFFFE50, 32'h00001234, 32'h00000000, 32'h00000000,
                   1'b1, 32'h0000FE50, 32'h00065000, 32'hFFFFFE50};
        vecs[2] = {16'hFFD0, 1'b1, 4'd0, 32'hFFFFFFD0, 32'h00002000, 32'h00000000, 32'h00000000,
                   1'b1, 32'hFFD00000, 32'h00009000, 32'hFFFFFFD0};
        vecs[3] = {16'hFE10, 1'b0, 4'd0, 32'hFFFFFE10, 32'h0000ABCC, 32'h000F2020, 32'h12345678,
                   1'b1, 32'h1234FE10, 32'h000F5020, 32'hFFFFFE10};
        vecs[4] = {16'hFF90, 1'b1, 4'd3, 32'hFFFFFF90, 32'h80000000, 32'h00000004, 32'h5555AAAA,
                   1'b1, 32'hFF90AAAA, 32'h00039004, 32'hFFFFFF90};

        RESn = 1'b0; CE = 1'b1; IF = 1'b1; BOUND = 1'b1;
        drive_vec(vecs[3]);
        #12;
        chk("reset_strobes", {ACK, BUSY, HALT, SR_WE, PSW_WE, PC_LD, STATE_DBG}, 9'd0);
        chk("reset_sr_wd", SR_WD, 32'd0);
        chk("reset_psw_wd", PSW_WD, 32'd0);
        chk("reset_pc_new", {SR_SEL, PC_NEW}, 35'd0);
        IF = 1'b0;
        @(negedge CLK);
        RESn = 1'b1;

        // CE low: no ACK and no state change even with a pending exception at a boundary
        IF = 1'b1; CE = 1'b0;
        #1;
        chk("ce0_no_ack", ACK, 1'b0);
        @(posedge CLK);
        #1;
        chk("ce0_idle_hold", {STATE_DBG, BUSY}, 4'd0);
        IF = 1'b0; CE = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 5; i++) begin
            run_entry(vecs[i], (i == 1) ? 5 : 0, (i == 3) ? 3 : 0);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        // reset pulsed in SPSW: save of PC is the only strobe that may appear
        drive_vec(vecs[2]);
        IF = 1'b1; BOUND = 1'b1;
        #1;
        chk("rst_seq_ack", ACK, 1'b1);
        exp_q.push_back({4'd1, 1'b0, 3'd2, vecs[2].pc});
        @(posedge CLK);
        #1;
        IF = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        chk("spsw_strobe", {SR_WE, SR_SEL, STATE_DBG}, {1'b1, 3'd3, 3'd3});
        RESn = 1'b0;
        #1;
        chk("rst_async_idle", {STATE_DBG, BUSY, SR_WE, PSW_WE, PC_LD}, 8'd0);
        @(negedge CLK);
        RESn = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            #1;
            if (PSW_WE || PC_LD || BUSY) bad = 1'b1;
        end
        chk("rst_no_psw_pc", bad, 1'b0);
        chk("rst_queue", exp_q.size(), 0);

        // entry with PSW.NP already set
        vf = {16'hFF60, 1'b1, 4'd0, 32'hFFFFFF60, 32'h00003000, 32'h00008000, 32'h00000000,
              1'b1, 32'hFF600000, 32'h00009000, 32'hFFFFFF60};
`ifdef V810_FATAL_HALT_EN
        drive_vec(vf);
        IF = 1'b1; BOUND = 1'b1;
        #1;
        chk("fatal_ack", ACK, 1'b1);
        @(posedge CLK);
        #1;
        IF = 1'b0;
        @(negedge CLK);
        repeat (8) begin
            @(negedge CLK);
            #1;
            chk("fatal_halt", {HALT, BUSY, STATE_DBG, SR_WE, PSW_WE, PC_LD},
                {1'b1, 1'b1, 3'd7, 3'b000});
        end
        RESn = 1'b0;
        #1;
        chk("fatal_reset", {HALT, BUSY, STATE_DBG}, 5'd0);
        @(negedge CLK);
        RESn = 1'b1;
        @(negedge CLK);
`else
        run_entry(vf, 0, 0);
        chk("no_halt", HALT, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
